// File: rtl/jmb_pixel_stream_src.sv
// rtl/jmb_pixel_stream_src.sv - raster pixel source reading a frame from sync memory into a valid/ready stream
// Optional sof_out/eol_out outputs are enabled with JMB_PIXEL_SRC_SOF_EOL_EN.
module jmb_pixel_stream_src #(
  parameter int DATA_WIDTH = 8,
  parameter int LINE_WIDTH = 10,
  parameter int NUM_LINES  = 10,
  parameter int ADDR_WIDTH = 7,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] data_out
`ifdef JMB_PIXEL_SRC_SOF_EOL_EN
  ,
  output logic                  sof_out,
  output logic                  eol_out
`endif
);

  localparam int TOTAL = LINE_WIDTH * NUM_LINES;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int COL_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam int ROW_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

  localparam logic [CNT_W-1:0] TOTAL_C  = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(TOTAL - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_LINES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]      pix_cnt_q, pix_cnt_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;

  logic                  xfer;
  logic [2:0]            pending;

  assign valid_out   = (occ_q != 2'd0);
  assign data_out    = valid_out ? buf0_q : '0;
  assign xfer        = valid_out && ready_in;
  assign mem_rd_addr = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(rd_cnt_q);

`ifdef JMB_PIXEL_SRC_SOF_EOL_EN
  // Head pixel position is the transfer-side col/row, so these hold with data_out under stalls.
  assign sof_out = valid_out && (col_q == '0) && (row_q == '0);
  assign eol_out = valid_out && (col_q == LAST_COL);
`endif

  // Entries left after this edge; counting the pop keeps one read per clock with the sink ready.
  assign pending = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, xfer};

  always_comb begin
    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    col_d      = col_q;
    row_d      = row_q;
    mem_rd_en  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    inflight_d = 1'b0;

    if (xfer) begin
      pix_cnt_d = pix_cnt_q + 1'b1;
      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          rd_cnt_d  = '0;
          pix_cnt_d = '0;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if ((rd_cnt_q < TOTAL_C) && (pending < 3'd2)) begin
          mem_rd_en  = 1'b1;
          inflight_d = 1'b1;
          rd_cnt_d   = rd_cnt_q + 1'b1;
          if (rd_cnt_q == LAST_C) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (xfer && (pix_cnt_q == LAST_C)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_d   = S_IDLE;
        rd_cnt_d  = '0;
        pix_cnt_d = '0;
        col_d     = '0;
        row_d     = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Two-entry FIFO kept as a shift register: buf0 is always the head.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_q;
    case ({inflight_q, xfer})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = mem_rd_data;
        else               buf1_d = mem_rd_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = mem_rd_data;
        end else begin
          buf0_d = buf1_q;
          buf1_d = mem_rd_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rd_cnt_q   <= '0;
      pix_cnt_q  <= '0;
      col_q      <= '0;
      row_q      <= '0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_jmb_pixel_stream_src.sv
// tb/tb_jmb_pixel_stream_src.sv - directed self-checking bench for jmb_pixel_stream_src
// Define JMB_PIXEL_SRC_SOF_EOL_EN to also exercise sof_out/eol_out.
module tb_jmb_pixel_stream_src;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, mem_rd_en, valid_out;
  logic [6:0] mem_rd_addr;
  logic [7:0] mem_rd_data = 8'd0;
  logic       ready_in = 1'b0;
  logic [7:0] data_out;
`ifdef JMB_PIXEL_SRC_SOF_EOL_EN
  logic       sof_out, eol_out;
`endif

  jmb_pixel_stream_src dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .valid_out   (valid_out),
    .ready_in    (ready_in),
    .data_out    (data_out)
`ifdef JMB_PIXEL_SRC_SOF_EOL_EN
    ,
    .sof_out     (sof_out),
    .eol_out     (eol_out)
`endif
  );

  always #5 clock = ~clock;

  logic [7:0] mem [0:127];
  initial for (int i = 0; i < 128; i++) mem[i] = 8'(i);
  always @(posedge clock) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int         n_checks = 0;
  int         n_pass = 0;

  int         n_xfer = 0, n_done = 0, n_reads = 0;
  int         stall_err = 0, outst_err = 0, occ_err = 0, outst = 0;
  int         valid_rise_cyc = -1, done_cyc = -1;
  logic       busy_at_done = 1'b0;
  logic       prev_valid = 1'b0, prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;
  logic [7:0] got [$];
  int         xfer_cyc [$];
  logic [6:0] rd_addrs [$];
`ifdef JMB_PIXEL_SRC_SOF_EOL_EN
  logic [7:0] sof_vals [$];
  logic [7:0] eol_vals [$];
`endif

  // Observes the cycle ending at the next rising edge.
  always @(negedge clock) begin
    if (mem_rd_en) begin
      n_reads++;
      rd_addrs.push_back(mem_rd_addr);
    end
    if (valid_out && !prev_valid) valid_rise_cyc = cyc;
    prev_valid = valid_out;
    if (prev_stall && (!valid_out || data_out !== prev_data)) stall_err++;
    if (valid_out && ready_in) begin
      got.push_back(data_out);
      xfer_cyc.push_back(cyc);
      n_xfer++;
`ifdef JMB_PIXEL_SRC_SOF_EOL_EN
      if (sof_out) sof_vals.push_back(data_out);
      if (eol_out) eol_vals.push_back(data_out);
`endif
    end
    if (reset) outst = 0;
    else outst = outst + int'(mem_rd_en) - int'(valid_out && ready_in);
    if (outst > 2) outst_err++;
    if (dut.occ_q > 2'd2) begin
      occ_err++;
      $display("FAIL occupancy: occ_q=%0d required <=2", dut.occ_q);
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
      busy_at_done = busy;
    end
    prev_stall = valid_out && !ready_in && !reset;
    prev_data = data_out;
  end

  function automatic int seq_errs(input int base);
    int e = 0;
    if (got.size() != base + 100) e++;
    for (int i = 0; i < 100; i++) begin
      if (base + i < got.size()) begin
        if (got[base + i] !== 8'(i)) e++;
      end else begin
        e++;
      end
    end
    return e;
  endfunction

  task automatic pulse_start(output int scyc);
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    scyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clock); #1;
      if (n_done > base) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clock);
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_checks++; if (mem_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", mem_rd_en); else n_pass++;
    n_checks++; if (mem_rd_addr !== 7'd0) $display("FAIL reset_addr: got %0d want 0", mem_rd_addr); else n_pass++;
    n_checks++; if (valid_out !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_out); else n_pass++;
    n_checks++; if (data_out !== 8'd0) $display("FAIL reset_data: got %0d want 0", data_out); else n_pass++;
    reset = 1'b0;
    repeat (2) @(posedge clock);
  endtask

  task automatic test_stream;
    int gb, db, xb, scyc, e;
    bit to;
    gb = got.size(); db = n_done; xb = xfer_cyc.size();
    ready_in = 1'b1;
    pulse_start(scyc);
    n_checks++; if (busy !== 1'b1) $display("FAIL stream_busy: got %b want 1", busy); else n_pass++;
    wait_done(db, to);
    n_checks++; if (to) $display("FAIL stream_timeout: done not seen within 2000 cycles"); else n_pass++;
    repeat (3) @(posedge clock); #1;
    e = seq_errs(gb);
    n_checks++; if (e != 0) $display("FAIL stream_seq: %0d errors in %0d transfers, want 0..99", e, got.size() - gb); else n_pass++;
    n_checks++; if (valid_rise_cyc - scyc != 2) $display("FAIL stream_first_valid: latency %0d want 2", valid_rise_cyc - scyc); else n_pass++;
    n_checks++;
    if (xfer_cyc.size() - xb != 100 || xfer_cyc[xfer_cyc.size() - 1] - xfer_cyc[xb] != 99)
      $display("FAIL stream_no_bubbles: %0d transfers over span %0d want 100 over 99",
               xfer_cyc.size() - xb, xfer_cyc[xfer_cyc.size() - 1] - xfer_cyc[xb]);
    else n_pass++;
    n_checks++; if (n_done - db != 1) $display("FAIL stream_done_count: got %0d want 1", n_done - db); else n_pass++;
    n_checks++; if (done_cyc != xfer_cyc[xfer_cyc.size() - 1] + 1) $display("FAIL stream_done_timing: done at %0d want %0d", done_cyc, xfer_cyc[xfer_cyc.size() - 1] + 1); else n_pass++;
    n_checks++; if (busy_at_done !== 1'b0) $display("FAIL stream_busy_at_done: got %b want 0", busy_at_done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL stream_busy_after: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_backpressure;
    int gb, db, sb, ob, scyc, e;
    bit to;
    logic pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    gb = got.size(); db = n_done; sb = stall_err; ob = outst_err;
    ready_in = 1'b1;
    pulse_start(scyc);
    to = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      ready_in = pat[i % 4];
      @(posedge clock); #1;
      if (n_done > db) begin
        to = 1'b0;
        break;
      end
    end
    ready_in = 1'b1;
    repeat (3) @(posedge clock); #1;
    n_checks++; if (to) $display("FAIL bp_timeout: done not seen within 2000 cycles"); else n_pass++;
    e = seq_errs(gb);
    n_checks++; if (e != 0) $display("FAIL bp_seq: %0d errors in %0d transfers, want 0..99", e, got.size() - gb); else n_pass++;
    n_checks++; if (stall_err != sb) $display("FAIL bp_stable: %0d unstable stalls want 0", stall_err - sb); else n_pass++;
    n_checks++; if (outst_err != ob) $display("FAIL bp_outstanding: %0d cycles over 2 want 0", outst_err - ob); else n_pass++;
    n_checks++; if (n_done - db != 1) $display("FAIL bp_done_count: got %0d want 1", n_done - db); else n_pass++;
  endtask

  task automatic test_start_while_busy;
    int gb, db, xb, scyc, e;
    bit to;
    gb = got.size(); db = n_done; xb = n_xfer;
    ready_in = 1'b1;
    pulse_start(scyc);
    for (int i = 0; i < 500 && n_xfer - xb < 40; i++) begin
      @(posedge clock); #1;
    end
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(db, to);
    repeat (5) @(posedge clock); #1;
    n_checks++; if (to) $display("FAIL restart_timeout: done not seen within 2000 cycles"); else n_pass++;
    e = seq_errs(gb);
    n_checks++; if (e != 0) $display("FAIL restart_seq: %0d errors in %0d transfers, want 0..99", e, got.size() - gb); else n_pass++;
    n_checks++; if (n_done - db != 1) $display("FAIL restart_done_count: got %0d want 1", n_done - db); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL restart_busy_after: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid_frame;
    int db, xb, gb, scyc, e;
    bit to;
    db = n_done; xb = n_xfer;
    ready_in = 1'b1;
    pulse_start(scyc);
    for (int i = 0; i < 500 && n_xfer - xb < 56; i++) begin
      @(posedge clock); #1;
    end
    reset = 1'b1;
    #1;
    n_checks++; if (valid_out !== 1'b0) $display("FAIL midreset_valid: got %b want 0", valid_out); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy); else n_pass++;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (6) @(posedge clock); #1;
    n_checks++; if (n_done != db) $display("FAIL midreset_no_done: got %0d pulses want 0", n_done - db); else n_pass++;
    n_checks++; if (valid_out !== 1'b0) $display("FAIL midreset_idle_valid: got %b want 0", valid_out); else n_pass++;
    gb = got.size();
    pulse_start(scyc);
    wait_done(db, to);
    repeat (3) @(posedge clock); #1;
    n_checks++; if (to) $display("FAIL midreset_timeout: done not seen within 2000 cycles"); else n_pass++;
    e = seq_errs(gb);
    n_checks++; if (e != 0) $display("FAIL midreset_seq: %0d errors in %0d transfers, want 0..99", e, got.size() - gb); else n_pass++;
  endtask

  task automatic test_stall_at_start;
    int gb, db, rb, scyc, e;
    bit to;
    gb = got.size(); db = n_done; rb = rd_addrs.size();
    ready_in = 1'b0;
    pulse_start(scyc);
    repeat (20) @(posedge clock);
    #1;
    n_checks++; if (rd_addrs.size() - rb != 2) $display("FAIL stall_reads: got %0d want 2", rd_addrs.size() - rb); else n_pass++;
    n_checks++;
    if (rd_addrs.size() - rb < 2 || rd_addrs[rb] !== 7'd0 || rd_addrs[rb + 1] !== 7'd1)
      $display("FAIL stall_addrs: got %0d reads starting %0d want 0,1", rd_addrs.size() - rb, (rd_addrs.size() > rb) ? int'(rd_addrs[rb]) : -1);
    else n_pass++;
    n_checks++; if (valid_out !== 1'b1) $display("FAIL stall_valid: got %b want 1", valid_out); else n_pass++;
    n_checks++; if (data_out !== 8'd0) $display("FAIL stall_data: got %0d want 0", data_out); else n_pass++;
    ready_in = 1'b1;
    wait_done(db, to);
    repeat (3) @(posedge clock); #1;
    n_checks++; if (to) $display("FAIL stall_timeout: done not seen within 2000 cycles"); else n_pass++;
    e = seq_errs(gb);
    n_checks++; if (e != 0) $display("FAIL stall_seq: %0d errors in %0d transfers, want 0..99", e, got.size() - gb); else n_pass++;
  endtask

`ifdef JMB_PIXEL_SRC_SOF_EOL_EN
  task automatic test_sof_eol;
    int sb, eb, db, scyc, e;
    bit to;
    sb = sof_vals.size(); eb = eol_vals.size(); db = n_done;
    ready_in = 1'b1;
    pulse_start(scyc);
    wait_done(db, to);
    repeat (3) @(posedge clock); #1;
    n_checks++; if (to) $display("FAIL sof_eol_timeout: done not seen within 2000 cycles"); else n_pass++;
    n_checks++;
    if (sof_vals.size() - sb != 1 || sof_vals[sb] !== 8'd0)
      $display("FAIL sof: %0d pulses want 1 with value 0", sof_vals.size() - sb);
    else n_pass++;
    e = 0;
    if (eol_vals.size() - eb != 10) e++;
    for (int i = 0; i < 10; i++)
      if (eb + i >= eol_vals.size() || eol_vals[eb + i] !== 8'(10 * i + 9)) e++;
    n_checks++; if (e != 0) $display("FAIL eol: %0d errors over %0d pulses want 9,19..99", e, eol_vals.size() - eb); else n_pass++;
  endtask
`endif

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_start_while_busy;
    test_reset_mid_frame;
    test_stall_at_start;
`ifdef JMB_PIXEL_SRC_SOF_EOL_EN
    test_sof_eol;
`endif
    n_checks++; if (occ_err != 0) $display("FAIL occupancy_total: %0d violations want 0", occ_err); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
